// File: rtl/vend_coin_scheduler.sv
// rtl/vend_coin_scheduler.sv - coin arbiter, credit accumulator and vend/change sequencer
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   nickel_a, dime_a              slot A coin pulses (one cycle per coin)
//   nickel_b, dime_b              slot B coin pulses
//   price_wr, price_in[5:0]       price load strobe and value (cents)
//   cancel                        customer cancel pulse
//   vend_ack                      dispense mechanism accepts the vend
//   vend_req                      dispense request, held until acknowledged
//   change_nickel                 one pulse per 5 cents returned
//   credit[5:0]                   current credit in cents
//   busy                          high in VEND, CHANGE and REFUND
//   coin_reject                   pulse when a coin is sent to the return chute
module vend_coin_scheduler #(
  parameter int PRICE_DEFAULT  = 15,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nickel_a,
  input  logic       dime_a,
  input  logic       nickel_b,
  input  logic       dime_b,
  input  logic       price_wr,
  input  logic [5:0] price_in,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic       vend_req,
  output logic       change_nickel,
  output logic [5:0] credit,
  output logic       busy,
  output logic       coin_reject
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, REFUND} state_t;

  state_t        state;
  logic [5:0]    price;
  logic [TW-1:0] timer;
  logic          hold_a_v, hold_a_dime;
  logic          hold_b_v, hold_b_dime;
  logic          rr_b;  // round-robin pointer names slot B when set

  logic       arb_en, gnt_a, gnt_b, gnt;
  logic [5:0] gnt_val, sum;
  logic       coin_a, coin_b, cap_a, cap_b, rej_a, rej_b;
  logic       price_ok;

  always_comb begin
    // A cancel in COLLECT wins over a grant, so the coin stays held.
    arb_en   = (state == IDLE) || ((state == COLLECT) && !cancel);
    gnt_a    = arb_en && hold_a_v && (!hold_b_v || !rr_b);
    gnt_b    = arb_en && hold_b_v && (!hold_a_v || rr_b);
    gnt      = gnt_a || gnt_b;
    if (gnt_a) gnt_val = hold_a_dime ? 6'd10 : 6'd5;
    else       gnt_val = hold_b_dime ? 6'd10 : 6'd5;
    sum      = credit + gnt_val;
    // A register being granted this cycle frees its slot for a new coin.
    coin_a   = nickel_a || dime_a;
    coin_b   = nickel_b || dime_b;
    cap_a    = coin_a && !(nickel_a && dime_a) && (!hold_a_v || gnt_a);
    cap_b    = coin_b && !(nickel_b && dime_b) && (!hold_b_v || gnt_b);
    rej_a    = coin_a && !cap_a;
    rej_b    = coin_b && !cap_b;
    price_ok = (price_in >= 6'd5) && (price_in <= 6'd50) && ((price_in % 6'd5) == 6'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_a_v    <= 1'b0;
      hold_a_dime <= 1'b0;
      hold_b_v    <= 1'b0;
      hold_b_dime <= 1'b0;
      rr_b        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      if (cap_a) begin
        hold_a_v    <= 1'b1;
        hold_a_dime <= dime_a;
      end else if (gnt_a) begin
        hold_a_v    <= 1'b0;
      end
      if (cap_b) begin
        hold_b_v    <= 1'b1;
        hold_b_dime <= dime_b;
      end else if (gnt_b) begin
        hold_b_v    <= 1'b0;
      end
      if (gnt_a)      rr_b <= 1'b1;
      else if (gnt_b) rr_b <= 1'b0;
      coin_reject <= rej_a || rej_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      price         <= 6'(PRICE_DEFAULT);
      timer         <= '0;
      credit        <= 6'd0;
      vend_req      <= 1'b0;
      change_nickel <= 1'b0;
      busy          <= 1'b0;
    end else begin
      change_nickel <= 1'b0;
      case (state)
        IDLE: begin
          if (price_wr && price_ok) price <= price_in;
          if (gnt) begin
            credit <= sum;
            timer  <= T_LOAD;
            if (sum >= price) begin
              state    <= VEND;
              vend_req <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (cancel) begin
            state <= REFUND;
            busy  <= 1'b1;
          end else if (gnt) begin
            credit <= sum;
            timer  <= T_LOAD;
            if (sum >= price) begin
              state    <= VEND;
              vend_req <= 1'b1;
              busy     <= 1'b1;
            end
          end else if (timer <= T_ONE) begin
            // Counter hits zero on this edge: exactly TIMEOUT_CYCLES after the last grant.
            timer <= '0;
            state <= REFUND;
            busy  <= 1'b1;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        VEND: begin
          if (vend_ack) begin
            vend_req <= 1'b0;
            credit   <= credit - price;
            if (credit > price) begin
              state <= CHANGE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE, REFUND: begin
          if (credit == 6'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            change_nickel <= 1'b1;
            credit        <= credit - 6'd5;
            if (credit <= 6'd5) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          vend_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_coin_scheduler.sv
// tb/tb_vend_coin_scheduler.sv - directed self-checking bench for vend_coin_scheduler
module tb_vend_coin_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       nickel_a = 0, dime_a = 0, nickel_b = 0, dime_b = 0;
  logic       price_wr = 0;
  logic [5:0] price_in = '0;
  logic       cancel = 0, vend_ack = 0;
  logic       vend_req, change_nickel, busy, coin_reject;
  logic [5:0] credit;

  int n_cmp = 0;
  int n_err = 0;

  vend_coin_scheduler #(.PRICE_DEFAULT(15), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .nickel_a(nickel_a), .dime_a(dime_a), .nickel_b(nickel_b), .dime_b(dime_b),
    .price_wr(price_wr), .price_in(price_in),
    .cancel(cancel), .vend_ack(vend_ack),
    .vend_req(vend_req), .change_nickel(change_nickel), .credit(credit),
    .busy(busy), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    steps(2);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset values
    steps(2);
    check("rst_credit", credit, 0);
    check("rst_vend_req", vend_req, 0);
    check("rst_busy", busy, 0);
    check("rst_change", change_nickel, 0);
    check("rst_reject", coin_reject, 0);
    reset_n = 1'b1;

    // Three nickels at price 15, then ack with no change
    nickel_a = 1; step(); nickel_a = 0;
    step(); check("t1_credit5", credit, 5);
    step();
    nickel_a = 1; step(); nickel_a = 0;
    step(); check("t1_credit10", credit, 10);
    step();
    nickel_a = 1; step(); nickel_a = 0;
    step(); check("t1_credit15", credit, 15);
    check("t1_vend_req", vend_req, 1);
    check("t1_busy", busy, 1);
    steps(2); check("t1_req_held", vend_req, 1);
    vend_ack = 1; step(); vend_ack = 0;
    check("t1_ack_credit", credit, 0);
    check("t1_ack_req", vend_req, 0);
    check("t1_ack_busy", busy, 0);
    step(); check("t1_no_change", change_nickel, 0);

    // Two dimes together, one nickel of change
    do_reset();
    dime_a = 1; dime_b = 1; step(); dime_a = 0; dime_b = 0;
    step(); check("t2_first", credit, 10);
    check("t2_first_req", vend_req, 0);
    step(); check("t2_second", credit, 20);
    check("t2_req", vend_req, 1);
    vend_ack = 1; step(); vend_ack = 0;
    check("t2_rem", credit, 5);
    check("t2_busy_chg", busy, 1);
    check("t2_chg_not_yet", change_nickel, 0);
    step(); check("t2_chg_pulse", change_nickel, 1);
    check("t2_chg_credit", credit, 0);
    check("t2_idle_busy", busy, 0);
    step(); check("t2_chg_single", change_nickel, 0);

    // Slot A held while slot B wins: second nickel_a rejected
    do_reset();
    nickel_a = 1; step();
    nickel_b = 1; step(); nickel_b = 0;
    check("t3_credit5", credit, 5);
    check("t3_no_reject", coin_reject, 0);
    step(); nickel_a = 0;
    check("t3_credit10", credit, 10);
    check("t3_reject", coin_reject, 1);
    step();
    check("t3_reject_end", coin_reject, 0);
    check("t3_credit15", credit, 15);
    check("t3_vend", vend_req, 1);

    // Price 25, dime then cancel: two refund nickels
    do_reset();
    price_in = 6'd25; price_wr = 1; step(); price_wr = 0;
    dime_a = 1; step(); dime_a = 0;
    step(); check("t4_credit", credit, 10);
    cancel = 1; step(); cancel = 0;
    check("t4_refund_busy", busy, 1);
    check("t4_hold_credit", credit, 10);
    step(); check("t4_n1", change_nickel, 1);
    check("t4_c1", credit, 5);
    step(); check("t4_n2", change_nickel, 1);
    check("t4_c2", credit, 0);
    check("t4_idle", busy, 0);
    step(); check("t4_n_end", change_nickel, 0);

    // Timeout of 8 cycles after the single grant
    do_reset();
    nickel_a = 1; step(); nickel_a = 0;
    step(); check("t5_credit", credit, 5);
    steps(7); check("t5_not_yet", busy, 0);
    step(); check("t5_refund", busy, 1);
    step(); check("t5_nickel", change_nickel, 1);
    check("t5_credit0", credit, 0);
    step(); check("t5_done", change_nickel, 0);

    // Price writes: ignored in COLLECT, ignored when illegal, taken in IDLE
    do_reset();
    nickel_a = 1; step(); nickel_a = 0;
    step();
    price_in = 6'd30; price_wr = 1; step(); price_wr = 0;
    dime_a = 1; step(); dime_a = 0;
    step(); check("t6_vend15", vend_req, 1);
    vend_ack = 1; step(); vend_ack = 0;
    check("t6_c0", credit, 0);
    price_in = 6'd33; price_wr = 1; step(); price_wr = 0;
    dime_a = 1; dime_b = 1; step(); dime_a = 0; dime_b = 0;
    steps(2); check("t6_bad_price", vend_req, 1);
    vend_ack = 1; step(); vend_ack = 0;
    steps(2); check("t6_back_idle", busy, 0);
    price_in = 6'd30; price_wr = 1; step(); price_wr = 0;
    dime_a = 1; dime_b = 1; step(); dime_a = 0; dime_b = 0;
    steps(2); check("t6_p30_c20", credit, 20);
    check("t6_p30_noreq", vend_req, 0);
    dime_a = 1; step(); dime_a = 0;
    step(); check("t6_p30_vend", vend_req, 1);
    vend_ack = 1; step(); vend_ack = 0;
    check("t6_p30_c0", credit, 0);

    // Reset pulsed while in CHANGE
    do_reset();
    dime_a = 1; dime_b = 1; step(); dime_a = 0; dime_b = 0;
    steps(2);
    vend_ack = 1; step(); vend_ack = 0;
    check("t7_in_change", credit, 5);
    reset_n = 1'b0; #1;
    check("t7_rst_credit", credit, 0);
    check("t7_rst_change", change_nickel, 0);
    check("t7_rst_busy", busy, 0);
    step(); reset_n = 1'b1;
    step(); check("t7_no_pulse", change_nickel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_coin_scheduler.md
# vend_coin_scheduler

Front-end controller for the vending datapath. Merges coin pulses from two independent coin slots through a round-robin arbiter and accumulates credit against a programmable price. Issues a vend request/acknowledge handshake to the dispense mechanism, then returns change, or refunds the full credit on cancel or inactivity timeout.

## Interface
- PRICE_DEFAULT, 15: price in cents loaded at reset; multiple of 5, 5..50.
- TIMEOUT_CYCLES, 1000: idle cycles in COLLECT before an automatic refund; ≥2.
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's job.
- nickel_a, dime_a  input  1 each  slot A coin pulses, one cycle per coin, synchronous to clk.
- nickel_b, dime_b  input  1 each  slot B coin pulses.
- price_wr  input  1  price load strobe.
- price_in  input  6  new price in cents.
- cancel  input  1  customer cancel, single-cycle pulse.
- vend_ack  input  1  dispense mechanism accepts vend.
- vend_req  output  1  request dispense; level, held until acked.
- change_nickel  output  1  one-cycle pulse per 5 cents returned.
- credit  output  6  current credit in cents.
- busy  output  1  high in VEND, CHANGE and REFUND.
- coin_reject  output  1  one-cycle pulse when a coin is dropped; the coin goes to the return chute.

## Operation
- Reset values: state IDLE, credit 0, price PRICE_DEFAULT, vend_req 0, change_nickel 0, busy 0, coin_reject 0, both holding registers empty, RR pointer on slot A, timeout counter 0.
- Per-slot holding register, 1 entry, stores value 5 or 10. On a coin pulse:
  - Register empty, or emptied by a grant this cycle: the coin is captured.
  - Otherwise: coin_reject fires.
  - nickel and dime both high on the same slot: coin_reject fires and nothing is captured.
  - Both slots rejecting in the same cycle: a single coin_reject pulse.
- Arbiter: runs only in IDLE and COLLECT, granting at most one holding register per cycle.
  - Both valid: grant the slot the pointer names, then point to the other slot.
  - One valid: grant it, then point to the other slot.
- Granted coin: credit += value; the holding register is cleared on the same edge.
- States:
  - IDLE: credit 0. A grant moves to COLLECT, or straight to VEND if the value ≥ price.
  - COLLECT: each grant reloads the timeout counter to TIMEOUT_CYCLES. When credit after a grant ≥ price, go to VEND with vend_req=1. cancel, or the counter reaching 0, goes to REFUND; cancel takes priority over a same-cycle grant, and that coin stays held.
  - VEND: vend_req=1 and no grants; holding registers keep their contents, and new coins follow the normal reject rule. cancel is ignored. On the vend_ack edge: credit -= price, vend_req=0, then CHANGE if the remainder is >0, else IDLE.
  - CHANGE and REFUND: change_nickel pulses every cycle with credit -= 5. When credit reaches 0 (same edge as the last pulse), go to IDLE.
- Price load: price_wr is honoured only in IDLE with price_in a multiple of 5 in 5..50; all other writes are silently ignored.
- Width: credit never exceeds price+5 ≤ 55, so it fits 6 bits with no saturation logic.

## Timing
- Coin pulse at edge k: captured at edge k. If granted at edge k+1, credit, state and vend_req update at edge k+1, giving one cycle of latency.
- vend_ack is sampled only while vend_req=1; an ack outside VEND is ignored.
- The first change_nickel occurs the cycle after leaving VEND or entering REFUND. N nickels take N consecutive cycles.
- Timeout: REFUND is entered exactly TIMEOUT_CYCLES cycles after the last grant with no further grant.
- reset_n low at any time: outputs are forced to reset values immediately, and any in-flight refund or change is abandoned.

## Test plan
- Price 15, nickel_a at cycles 0, 3, 6: credit goes 5, 10, 15. vend_req rises at edge 7; ack at 9 gives credit 0, IDLE, and no change_nickel.
- Price 15, dime_a and dime_b in the same cycle after reset: slot A granted first (credit 10), then B (credit 20) and VEND. After ack, exactly one change_nickel, then IDLE.
- Price 15, nickel_a twice in consecutive cycles while slot A is held by a pending slot B win: the second nickel gives coin_reject=1 for one cycle, with credit unaffected.
- Price 25, dime_a then cancel: REFUND emits exactly 2 change_nickel pulses on consecutive cycles, then credit 0 and IDLE.
- TIMEOUT_CYCLES=8, single nickel then silence: REFUND is entered 8 cycles after the grant, giving one change_nickel.
- price_wr=30 during COLLECT is ignored (vend at 15); price_wr=33 in IDLE is ignored; price_wr=30 in IDLE takes effect. reset_n pulsed low mid-CHANGE: change_nickel=0 and credit=0 immediately.
